data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Services the Memory Access stage's load/store requests (mem_read, mem_write, address, data, func3).
//   Word-organised on-chip data RAM with programmable multi-cycle latency, byte/half/word lanes, and load sign/zero extension.
//   Raises busywait so the pipeline holds EX_MA/MA_WB until the access completes.
// PARAMETERS
//   DEPTH_WORDS  256  number of 32-bit words; power of two, >=4
//   LATENCY      3    cycles busywait is high per access; legal range 1..15
// PORTS
//   CLK            in   1   single clock; all state updates on posedge
//   RESET          in   1   synchronous, active-low reset
//   mem_read       in   1   load request; held stable by CPU while busywait=1
//   mem_write      in   1   store request; held stable by CPU while busywait=1
//   address        in   32  byte address (ALU result)
//   write_data     in   32  store data (rs2); low byte/half used for SB/SH
//   func3          in   3   RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   busywait       out  1   stall request to pipeline
//   read_data      out  32  load result, extended per func3
//   access_err     out  1   one-cycle pulse: misaligned, illegal func3, or read+write together
// BEHAVIOUR
//   Reset (RESET=0 at posedge): state<=IDLE, counter<=0, read_data<=0, access_err<=0. RAM contents not cleared.
//   States: IDLE, BUSY, DONE.
//   IDLE:
//     - req = mem_read|mem_write.
//     - busywait = req, combinational in IDLE (stalls in the request cycle itself).
//     - On req: latch address, write_data, func3, rd/wr; counter<=LATENCY-1.
//     - If LATENCY==1, go directly to DONE; otherwise go to BUSY.
//   BUSY:
//     - busywait=1; counter decrements each cycle.
//     - On the edge where counter==1: commit store or capture load into read_data; go to DONE.
//   DONE:
//     - busywait=0; read_data valid for exactly this cycle and holds until the next load completes.
//     - Request inputs still show the old access this cycle; ignore them. Next state is always IDLE.
//   Latency: request seen at cycle 0; busywait=1 for cycles 0..LATENCY-1, =0 at cycle LATENCY.
//     - Back-to-back accesses: a new request is accepted at cycle LATENCY+1.
//   Store: word-index = address[log2(DEPTH_WORDS)+1:2], wraps modulo DEPTH; byte-enable from address[1:0] and func3.
//     - SB writes one lane; SH writes lanes {1,0} or {3,2}; SW writes all four. Other lanes are untouched.
//   Load: select lane(s) by address[1:0]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
//   Errors (checked at acceptance; full latency still elapses so stall timing is uniform):
//     - H with address[0]=1, W with address[1:0]!=0, func3 in {011,110,111}, or mem_read&mem_write.
//     - No RAM write; read_data<=0; access_err=1 in the DONE cycle only.
//   Reset mid-access: abort to IDLE; a store not yet at its commit edge is never written; busywait drops the next cycle.
//   RESET and commit on the same edge: reset wins, no write.
// STRUCTURE
//   Shared package mem_pkg: F3_B/F3_H/F3_W/F3_BU/F3_HU localparams, state encoding IDLE/BUSY/DONE,
//     and a byte-enable function shared with a future data cache.
//   Sub-module mem_lane_align: combinational store byte-enable/data replication plus load extract/extend.
//   Top holds the FSM, counter, latches and RAM array.
// TESTING
//   1. LATENCY=3: SW 0xDEADBEEF @0x10, then LW @0x10 -> busywait high 3 cycles each; read_data=0xDEADBEEF in the DONE cycle.
//   2. SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> bytes 0,2,3 unchanged.
//   3. SH 0x8001 @0x32; LH -> 0xFFFF8001; LHU -> 0x00008001; LH @0x31 -> access_err pulse, read_data=0, word @0x30 unchanged.
//   4. Hold mem_read through the DONE cycle, then present a new LW -> exactly one access per request; new busywait at cycle LATENCY+1.
//   5. SW @0x40 with RESET low at cycle 1 -> IDLE next cycle, busywait=0; LW @0x40 returns the prior value.
//   6. DEPTH_WORDS=256: SW 0x1234 @0x400 -> LW @0x000 returns 0x1234 (wrap); mem_read=mem_write=1 -> access_err, no write.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: width codes, responder state encoding and lane helpers shared by data-side memories
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [3:0] lane_enable(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == 2'b10 ? 4'hf : f3[1:0] == 2'b01 ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
  endfunction
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] off);
    return f3 == 3'b011 || f3[2:1] == 2'b11 || (f3[1:0] == 2'b01 && off[0]) ||
           (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-enable/data replication and load lane extract with sign/zero extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] ram_word,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  output logic [31:0] load_data
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  // Replicate store data across lanes and shift the addressed lane(s) down for loads
  always_comb begin
    byte_en   = lane_enable(func3, offset);
    lane_data = func3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                func3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    shifted   = ram_word >> {offset, 3'b000};
    b         = shifted[7:0];
    h         = shifted[15:0];
    load_data = func3 == F3_B  ? {{24{b[7]}}, b} :
                func3 == F3_BU ? {24'b0, b} :
                func3 == F3_H  ? {{16{h[15]}}, h} :
                func3 == F3_HU ? {16'b0, h} : ram_word;
  end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle data RAM servicing MA-stage loads/stores with busywait stall
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  func3,
  output logic        busywait,
  output logic [31:0] read_data,
  output logic        access_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t      state, state_n;
  logic [3:0]  counter;
  logic        rd_q, wr_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [31:0] ram [DEPTH_WORDS];
  logic        req, idle, commit;
  logic        c_rd, c_wr, c_err;
  logic [AW+1:0] c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_f3;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] lane_data, load_data;
  logic        unused_bits;
  assign unused_bits = ^address[31:AW+2];
  // With LATENCY==1 the commit edge is the acceptance edge, so operands come live from the ports in IDLE
  always_comb begin
    req      = mem_read | mem_write;
    idle     = state == IDLE;
    c_rd     = idle ? mem_read : rd_q;
    c_wr     = idle ? mem_write : wr_q;
    c_addr   = idle ? address[AW+1:0] : addr_q;
    c_wdata  = idle ? write_data : wdata_q;
    c_f3     = idle ? func3 : f3_q;
    c_err    = access_bad(c_f3, c_addr[1:0]) | (c_rd & c_wr);
    idx      = c_addr[AW+1:2];
    busywait = state == BUSY || (idle && req);
    commit   = (idle && req && LATENCY == 1) || (state == BUSY && counter == 4'd1);
    state_n  = idle ? (req ? (LATENCY == 1 ? DONE : BUSY) : IDLE) :
               state == BUSY ? (counter == 4'd1 ? DONE : BUSY) : IDLE;
  end
  mem_lane_align u_align (
    .func3      (c_f3),
    .offset     (c_addr[1:0]),
    .store_data (c_wdata),
    .ram_word   (ram[idx]),
    .byte_en    (be),
    .lane_data  (lane_data),
    .load_data  (load_data)
  );
  // FSM, latency counter and load/error result registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      counter    <= 4'd0;
      read_data  <= 32'd0;
      access_err <= 1'b0;
    end else begin
      state      <= state_n;
      access_err <= commit & c_err;
      if (idle && req) counter <= 4'(LATENCY - 1);
      else if (state == BUSY) counter <= counter - 4'd1;
      if (commit && (c_rd || c_err)) read_data <= c_err ? 32'd0 : load_data;
    end
  end
  // Capture the request at acceptance so the access is immune to input changes during DONE
  always_ff @(posedge CLK) begin
    if (idle && req) begin
      rd_q    <= mem_read;
      wr_q    <= mem_write;
      addr_q  <= address[AW+1:0];
      wdata_q <= write_data;
      f3_q    <= func3;
    end
  end
  // Byte-lane store commit; reset on the commit edge suppresses the write
  always_ff @(posedge CLK) begin
    if (RESET && commit && c_wr && !c_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= lane_data[8*i +: 8];
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for load/store results, latency, errors and reset abort
module tb_data_memory_responder;
  localparam int LAT = 3;
  logic        CLK = 0, RESET = 0, mem_read = 0, mem_write = 0;
  logic [31:0] address = 0, write_data = 0;
  logic [2:0]  func3 = 0;
  logic        busywait, access_err;
  logic [31:0] read_data;
  typedef struct packed {logic chk; logic [31:0] data; logic err;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .func3(func3),
    .busywait(busywait), .read_data(read_data), .access_err(access_err)
  );

  always #5 CLK = ~CLK;

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input logic chk, input logic [31:0] d, input logic e);
    int n;
    mem_read = rd; mem_write = wr; address = a; write_data = wd; func3 = f3;
    q.push_back('{chk, d, e});
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (busywait && n < 40);
    if (busywait) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h busywait stuck", a);
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    mem_read = 0; mem_write = 0;
    @(posedge CLK); #1;
  endtask

  task automatic abort_store(input logic [31:0] a, input logic [31:0] wd, input int rc);
    mem_read = 0; mem_write = 1; address = a; write_data = wd; func3 = 3'b010;
    repeat (rc) begin @(posedge CLK); #1; end
    RESET = 0;
    @(posedge CLK); #1;
    RESET = 1; mem_write = 0;
    @(posedge CLK); #1;
  endtask

  initial begin : monitor
    logic prev_bw, prev_rst;
    int bw_n;
    exp_t x;
    prev_bw = 0; prev_rst = 0; bw_n = 0;
    forever begin
      @(negedge CLK);
      if (prev_rst) begin
        checks += 2;
        if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait got=%b want=0", busywait); end
        if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data got=%h want=00000000", read_data); end
        bw_n = 0;
      end else if (prev_bw && !busywait) begin
        checks += 2;
        if (bw_n != LAT) begin errors++; $display("FAIL latency got=%0d want=%0d", bw_n, LAT); end
        if (q.size() == 0) begin
          errors++; $display("FAIL unexpected_done read_data=%h", read_data);
        end else begin
          x = q.pop_front();
          if (access_err !== x.err) begin errors++; $display("FAIL access_err got=%b want=%b", access_err, x.err); end
          if (x.chk) begin
            checks++;
            if (read_data !== x.data) begin errors++; $display("FAIL read_data got=%h want=%h", read_data, x.data); end
          end
        end
        bw_n = 0;
      end
      bw_n = busywait ? bw_n + 1 : 0;
      prev_bw = busywait;
      prev_rst = !RESET;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) begin @(posedge CLK); #1; end
    RESET = 1;
    idle();
    issue(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 0, 0);
    issue(1, 0, 32'h10, 0, 3'b010, 1, 32'hDEADBEEF, 0);
    idle();
    issue(0, 1, 32'h20, 32'h11223344, 3'b010, 0, 0, 0);
    issue(0, 1, 32'h21, 32'hABCDEF80, 3'b000, 0, 0, 0);
    issue(1, 0, 32'h21, 0, 3'b000, 1, 32'hFFFFFF80, 0);
    issue(1, 0, 32'h21, 0, 3'b100, 1, 32'h00000080, 0);
    issue(1, 0, 32'h20, 0, 3'b010, 1, 32'h11228044, 0);
    idle();
    issue(0, 1, 32'h30, 32'h55667788, 3'b010, 0, 0, 0);
    issue(0, 1, 32'h32, 32'h12348001, 3'b001, 0, 0, 0);
    issue(1, 0, 32'h32, 0, 3'b001, 1, 32'hFFFF8001, 0);
    issue(1, 0, 32'h32, 0, 3'b101, 1, 32'h00008001, 0);
    issue(1, 0, 32'h31, 0, 3'b001, 1, 32'h0, 1);
    issue(1, 0, 32'h30, 0, 3'b010, 1, 32'h80017788, 0);
    issue(1, 0, 32'h10, 0, 3'b010, 1, 32'hDEADBEEF, 0);
    issue(1, 0, 32'h20, 0, 3'b010, 1, 32'h11228044, 0);
    idle();
    issue(0, 1, 32'h40, 32'hCAFEF00D, 3'b010, 0, 0, 0);
    idle();
    abort_store(32'h40, 32'h99999999, 1);
    issue(1, 0, 32'h40, 0, 3'b010, 1, 32'hCAFEF00D, 0);
    idle();
    abort_store(32'h40, 32'h77777777, 2);
    issue(1, 0, 32'h40, 0, 3'b010, 1, 32'hCAFEF00D, 0);
    idle();
    issue(0, 1, 32'h400, 32'h00001234, 3'b010, 0, 0, 0);
    issue(1, 0, 32'h000, 0, 3'b010, 1, 32'h00001234, 0);
    issue(1, 1, 32'h000, 32'hFFFFFFFF, 3'b010, 1, 32'h0, 1);
    issue(1, 0, 32'h000, 0, 3'b010, 1, 32'h00001234, 0);
    issue(1, 0, 32'h12, 0, 3'b010, 1, 32'h0, 1);
    issue(1, 0, 32'h10, 0, 3'b011, 1, 32'h0, 1);
    issue(1, 0, 32'h10, 0, 3'b110, 1, 32'h0, 1);
    issue(1, 0, 32'h13, 0, 3'b100, 1, 32'h000000DE, 0);
    idle();
    repeat (3) idle();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL pending_responses got=%0d want=0", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
